// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder: CHUNK bits per clock, with the carry held in a register between chunks.
// Optional signed-overflow flag is built when CHUNK_SERIAL_ADDER_OFL_EN is defined.
module chunk_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             Ofl
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  // Handshake: start is sampled on a rising edge in IDLE or DONE and is ignored
  // in BUSY; done is a one-cycle pulse during which S/C_out/Ofl are freshly valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, s_q;
  logic             cout_q;

  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic [CHUNK:0]   chunk_sum_d;
  logic [WIDTH-1:0] acc_d;
  logic             last_d;
  int               base_d;

  always_comb begin
    base_d      = int'(idx_q) * CHUNK;
    chunk_a     = a_q[base_d +: CHUNK];
    chunk_b     = b_q[base_d +: CHUNK];
    chunk_sum_d = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
    acc_d       = acc_q;
    acc_d[base_d +: CHUNK] = chunk_sum_d[CHUNK-1:0];
    last_d      = (idx_q == LAST_IDX);
  end

`ifdef CHUNK_SERIAL_ADDER_OFL_EN
  logic ofl_q;
  logic ofl_d;
  always_comb begin
    ofl_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
  end
  assign Ofl = ofl_q;
`else
  assign Ofl = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef CHUNK_SERIAL_ADDER_OFL_EN
      ofl_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= C_in;
            idx_q   <= '0;
            state_q <= BUSY;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          acc_q   <= acc_d;
          carry_q <= chunk_sum_d[CHUNK];
          idx_q   <= idx_q + IDX_W'(1);
          // Results are published only on the final chunk, so the partial
          // accumulator never reaches the outputs.
          if (last_d) begin
            state_q <= DONE;
            s_q     <= acc_d;
            cout_q  <= chunk_sum_d[CHUNK];
`ifdef CHUNK_SERIAL_ADDER_OFL_EN
            ofl_q   <= ofl_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = (state_q == BUSY);
  assign done  = (state_q == DONE);
  assign S     = s_q;
  assign C_out = cout_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed bench for chunk_serial_adder (WIDTH=16, CHUNK=4); expected Ofl follows
// CHUNK_SERIAL_ADDER_OFL_EN.
module tb_chunk_serial_adder;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int NC = W / CH;
`ifdef CHUNK_SERIAL_ADDER_OFL_EN
  localparam bit OFL_EN = 1'b1;
`else
  localparam bit OFL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] s;
  logic         cout, ofl;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_s = '0;

  chunk_serial_adder #(.WIDTH(W), .CHUNK(CH)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .C_in(cin),
    .busy(busy), .done(done), .S(s), .C_out(cout), .Ofl(ofl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // One complete add; operand inputs are scrambled after acceptance, and
  // glitch pulses start with other operands during the second busy cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                        input logic cin_v, input logic [W-1:0] exp_s, input logic exp_c,
                        input logic ofl_if_en, input bit glitch);
    int cnt;
    @(negedge clk);
    a = a_v; b = b_v; cin = cin_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~a_v; b = ~b_v; cin = ~cin_v;
    check({tag, "_busy0"}, busy, 1);
    check({tag, "_hold"}, s, last_s);
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      if (glitch && cnt == 1) begin
        start = 1'b1; a = 16'hAAAA; b = 16'h5555;
      end else begin
        start = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_cycles"}, cnt, NC);
    check({tag, "_done"}, done, 1);
    check({tag, "_s"}, s, exp_s);
    check({tag, "_cout"}, cout, exp_c);
    check({tag, "_ofl"}, ofl, OFL_EN ? ofl_if_en : 1'b0);
    last_s = exp_s;
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s", s, 0);
    check("rst_cout", cout, 0);
    check("rst_ofl", ofl, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    run_op("ripple",  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("posovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("ignore",  16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
    run_op("negovf",  16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    // Abort in the third busy cycle of 0x00FF + 0x0001.
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy3", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_s", s, 0);
    check("abort_cout", cout, 0);
    check("abort_ofl", ofl, 0);
    @(negedge clk);
    rst = 1'b0;
    last_s = '0;
    @(negedge clk);
    check("abort_idle", busy, 0);
    run_op("after_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start held high through the DONE cycle.
    @(negedge clk);
    a = 16'h0010; b = 16'h0020; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    check("b2b_busy0", busy, 1);
    wait_busy(cnt);
    check("b2b_cycles1", cnt, NC);
    check("b2b_done1", done, 1);
    check("b2b_s1", s, 16'h0030);
    check("b2b_cout1", cout, 0);
    a = 16'h8000; b = 16'h8000;
    @(negedge clk);
    start = 1'b0;
    check("b2b_accept", busy, 1);
    check("b2b_nodone", done, 0);
    check("b2b_hold", s, 16'h0030);
    wait_busy(cnt);
    check("b2b_cycles2", cnt, NC);
    check("b2b_done2", done, 1);
    check("b2b_s2", s, 16'h0000);
    check("b2b_cout2", cout, 1);
    check("b2b_ofl2", ofl, OFL_EN ? 1 : 0);
    @(negedge clk);
    check("b2b_done_pulse", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chunk_serial_adder.md
Name: chunk_serial_adder

Overview:
Parametrised multi-cycle adder. Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, carry rippling between chunks through a register. Start/busy/done handshake. Used where a full WIDTH-bit ripple path is too long for one cycle, or where area must be traded for latency.

Parameters:
WIDTH, 16, operand and sum width in bits; must be >= 1.
CHUNK, 4, bits added per cycle; must divide WIDTH exactly. NUM_CHUNKS = WIDTH/CHUNK is a derived localparam.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a new add; sampled on clk rising edge.
A  input  WIDTH  operand A; captured on the accepting edge.
B  input  WIDTH  operand B; captured on the accepting edge.
C_in  input  1  carry-in; captured on the accepting edge.
busy  output  1  high while chunks are being computed.
done  output  1  one-cycle pulse; result is valid.
S  output  WIDTH  registered sum; holds the last completed result.
C_out  output  1  registered carry-out of the MSB chunk.
Ofl  output  1  registered signed-overflow flag (see Optional Feature).

Behaviour:
- Reset is asynchronous. While rst is high: state=IDLE, busy=0, done=0, S=0, C_out=0, Ofl=0, and the chunk counter, carry register and operand registers are all 0.
- State machine has three states: IDLE, BUSY, DONE.
- IDLE: if start=1 on an edge, latch A, B and C_in, load the carry register with C_in, set the chunk index to 0, and go to BUSY. Otherwise stay in IDLE.
- BUSY: on each edge, add chunk[idx] of A and B plus the carry register.
  - Write the CHUNK-bit sum into the matching chunk of an internal accumulator.
  - Update the carry register and increment idx.
  - When idx = NUM_CHUNKS-1 is processed, go to DONE. On the same edge, load S from the accumulator and C_out from the final carry.
- DONE: lasts exactly one cycle.
  - If start=1, accept new operands exactly as in IDLE and go to BUSY (back-to-back operation).
  - Otherwise go to IDLE.
- Output decodes: busy = (state==BUSY); done = (state==DONE).
- Latency: start accepted at edge k → busy high for cycles k..k+NUM_CHUNKS-1 → done high during the cycle following edge k+NUM_CHUNKS. With the defaults, done is high 4 cycles after the accepting edge.
- start while BUSY is ignored. Operands latched at acceptance are unaffected by later changes on A, B or C_in.
- S, C_out and Ofl change only on the edge that enters DONE. During BUSY and IDLE they hold the previous result. The accumulator is never visible on the outputs.
- CHUNK = WIDTH: NUM_CHUNKS=1, giving one BUSY cycle then DONE.
- Arithmetic is unsigned modulo 2^WIDTH. C_out is the true carry out of bit WIDTH-1.
- A rst assertion mid-BUSY or mid-DONE aborts the operation immediately. All outputs return to their reset values and the in-flight result is discarded.

Optional Feature:
Macro: CHUNK_SERIAL_ADDER_OFL_EN.
- Defined: Ofl is loaded on entry to DONE as (A_lat[WIDTH-1] == B_lat[WIDTH-1]) && (S_new[WIDTH-1] != A_lat[WIDTH-1]). A_lat and B_lat are the latched operands; S_new is the sum being loaded. This is two's-complement overflow, and C_in is included in the sum.
- Undefined: Ofl is tied to constant 0 and no overflow logic is generated.

Test Plan:
1. WIDTH=16, CHUNK=4; A=0x1234, B=0x4321, C_in=0, start for 1 cycle → busy high 4 cycles, then done pulses for 1 cycle; S=0x5555, C_out=0.
2. A=0xFFFF, B=0x0000, C_in=1 → S=0x0000, C_out=1; the carry propagates through all 4 chunk boundaries.
3. A=0x7FFF, B=0x0001, C_in=0 → S=0x8000, C_out=0; Ofl=1 with the macro defined, Ofl=0 without it.
4. Start an add of 0x0001+0x0001; during BUSY, pulse start with A=0xAAAA, B=0x5555 → second request ignored; single done pulse; S=0x0002; busy never re-extends.
5. rst asserted during the 3rd BUSY cycle of 0x00FF+0x0001 → busy, done, S, C_out and Ofl go to 0 asynchronously. After release, 0x0003+0x0004 completes with S=0x0007 after 4 busy cycles.
6. Hold start=1 through the DONE cycle of 0x0010+0x0020, with A=0x8000, B=0x8000 presented then → first done shows S=0x0030. The second op is accepted immediately; 4 busy cycles later done shows S=0x0000, C_out=1, and Ofl=1 if the macro is defined.
